// File: rtl/fifo_burst_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_drain_ctrl
// Brief    : Pops the register FIFO and forwards sop/eop-framed bursts; flushes
//            a partial burst after an idle timeout. Stats counters: DRAIN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_drain_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH_W   = 10,
  parameter int MAX_BURST = 16,
  parameter int TMO_W     = 12
) (
  input  logic               clockCore,
  input  logic               resetCore,
  input  logic               enable,
  input  logic [4:0]         cfgBurstLen,
  input  logic [TMO_W-1:0]   cfgTimeout,
  input  logic               fifoEmpty,
  input  logic [DEPTH_W-1:0] fifoDepth,
  input  logic [DATA_W-1:0]  fifoDataOut,
  output logic               fifoPop,
  output logic               txValid,
  output logic [DATA_W-1:0]  txData,
  output logic               txSop,
  output logic               txEop,
  input  logic               txReady,
  output logic               busy,
  output logic               popErr,
  output logic [15:0]        burstCount,
  output logic [15:0]        flushCount
);

  localparam int LEN_W = 5;
  localparam logic [LEN_W-1:0] c_maxBurst = LEN_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state, w_stateNext;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_first;
  logic [TMO_W-1:0]   r_timer;
  logic               r_txValid, r_txSop, r_txEop, r_popErr;
  logic [DATA_W-1:0]  r_txData;

  logic [LEN_W-1:0]   w_effLen, w_flushLen;
  logic               w_slotFree, w_depthBelow, w_flushDue;
  logic               w_pop, w_starved, w_startFull, w_startFlush;

  always_comb begin
    w_effLen = cfgBurstLen;
    if (cfgBurstLen == '0)
      w_effLen = LEN_W'(1);
    else if (cfgBurstLen > c_maxBurst)
      w_effLen = c_maxBurst;
  end

  assign w_slotFree   = !r_txValid || txReady;
  assign w_depthBelow = fifoDepth < DEPTH_W'(w_effLen);
  assign w_flushLen   = w_depthBelow ? fifoDepth[LEN_W-1:0] : w_effLen;
  assign w_flushDue   = (cfgTimeout != '0) && (r_timer == cfgTimeout - TMO_W'(1));

  always_comb begin
    w_stateNext  = r_state;
    w_pop        = 1'b0;
    w_starved    = 1'b0;
    w_startFull  = 1'b0;
    w_startFlush = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !w_depthBelow) begin
          w_startFull = 1'b1;
          w_stateNext = BURST;
        end else if (enable && (fifoDepth != '0) && w_flushDue) begin
          w_startFlush = 1'b1;
          w_stateNext  = BURST;
        end
      end
      BURST: begin
        if ((r_remaining != '0) && w_slotFree) begin
          if (fifoEmpty)
            w_starved = 1'b1;
          else
            w_pop = 1'b1;
        end
        if (w_pop && (r_remaining == LEN_W'(1)))
          w_stateNext = DONE;
      end
      DONE: begin
        if (r_txValid && txReady)
          w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_timer     <= '0;
      r_txValid   <= 1'b0;
      r_txData    <= '0;
      r_txSop     <= 1'b0;
      r_txEop     <= 1'b0;
      r_popErr    <= 1'b0;
    end else begin
      r_state <= w_stateNext;

      if (w_startFull) begin
        r_remaining <= w_effLen;
        r_first     <= 1'b1;
      end else if (w_startFlush) begin
        r_remaining <= w_flushLen;
        r_first     <= 1'b1;
      end else if (w_pop) begin
        r_remaining <= r_remaining - LEN_W'(1);
        r_first     <= 1'b0;
      end

      // Idle timer only runs while a partial burst is waiting; it saturates.
      if ((r_state != IDLE) || !enable || (fifoDepth == '0) || w_startFull || w_startFlush)
        r_timer <= '0;
      else if (w_depthBelow && (r_timer != '1))
        r_timer <= r_timer + TMO_W'(1);

      if (w_pop) begin
        r_txValid <= 1'b1;
        r_txData  <= fifoDataOut;
        r_txSop   <= r_first;
        r_txEop   <= (r_remaining == LEN_W'(1));
      end else if (w_slotFree) begin
        r_txValid <= 1'b0;
      end

      r_popErr <= r_popErr | w_starved;
    end
  end

  assign fifoPop = w_pop;
  assign txValid = r_txValid;
  assign txData  = r_txData;
  assign txSop   = r_txSop;
  assign txEop   = r_txEop;
  assign busy    = (r_state != IDLE);
  assign popErr  = r_popErr;

`ifdef DRAIN_STATS_EN
  logic [15:0] r_burstCount, r_flushCount;

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      r_burstCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (r_txValid && txReady && r_txEop)
        r_burstCount <= r_burstCount + 16'd1;
      if (w_startFlush)
        r_flushCount <= r_flushCount + 16'd1;
    end
  end

  assign burstCount = r_burstCount;
  assign flushCount = r_flushCount;
`else
  assign burstCount = '0;
  assign flushCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_drain_ctrl
// Brief    : Directed bench with a FIFO environment and a cycle model of the
//            drain controller; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_drain_ctrl;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        resetCore = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  cfgBurstLen = 5'd8;
  logic [11:0] cfgTimeout = 12'd0;
  logic        fifoEmpty;
  logic [9:0]  fifoDepth;
  logic [31:0] fifoDataOut;
  logic        fifoPop;
  logic        txValid;
  logic [31:0] txData;
  logic        txSop, txEop;
  logic        txReady = 1'b1;
  logic        busy, popErr;
  logic [15:0] burstCount, flushCount;

  fifo_burst_drain_ctrl dut (
    .clockCore(clk), .resetCore(resetCore), .enable(enable),
    .cfgBurstLen(cfgBurstLen), .cfgTimeout(cfgTimeout),
    .fifoEmpty(fifoEmpty), .fifoDepth(fifoDepth), .fifoDataOut(fifoDataOut),
    .fifoPop(fifoPop), .txValid(txValid), .txData(txData),
    .txSop(txSop), .txEop(txEop), .txReady(txReady),
    .busy(busy), .popErr(popErr),
    .burstCount(burstCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  // FIFO environment
  logic [31:0] q[$];
  int          pushN = 0;
  logic [31:0] nextWord = 32'hA500_0000;
  logic        forceEmpty = 1'b0;

  int total = 0, bad = 0, cyc = 0;
  int popCnt, sopCnt, eopCnt, bothCnt, accCnt, busyCnt, curRun, maxRun;
  int firstNz, firstPop;

  // Reference model state
  bit          mKnown = 0, mBurst = 0, mFirst = 0, mValid = 0, mSop = 0, mEop = 0, mErr = 0;
  int          mRem = 0, mTimer = 0;
  logic [31:0] mData = '0;
  logic [15:0] mBursts = '0, mFlushes = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic driveFifo();
    fifoDepth   = 10'(q.size());
    fifoEmpty   = forceEmpty || (q.size() == 0);
    fifoDataOut = (q.size() != 0) ? q[0] : 32'h0;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(nextWord);
      nextWord++;
    end
    driveFifo();
  endtask

  task automatic clearStats();
    popCnt = 0; sopCnt = 0; eopCnt = 0; bothCnt = 0; accCnt = 0;
    busyCnt = 0; curRun = 0; maxRun = 0; firstNz = -1; firstPop = -1;
  endtask

  task automatic cycle();
    int eff, depth, tmo;
    bit slot, pop, full, flush, doPop, rstNow;
    bit nBurst, nFirst, nValid, nSop, nEop, nErr;
    int nRem, nTimer;
    logic [31:0] nData;
    logic [15:0] nB, nF;
    @(negedge clk);
    eff   = (cfgBurstLen == 0) ? 1 : ((int'(cfgBurstLen) > MAXB) ? MAXB : int'(cfgBurstLen));
    depth = int'(fifoDepth);
    tmo   = int'(cfgTimeout);
    slot  = !mValid || txReady;
    pop   = mBurst && (mRem > 0) && slot && !fifoEmpty;
    if (mKnown) begin
      chk("fifoPop", fifoPop, pop);
      chk("txValid", txValid, mValid);
      if (mValid) begin
        chk("txData", txData, mData);
        chk("txSop", txSop, mSop);
        chk("txEop", txEop, mEop);
      end
      chk("busy", busy, mBurst);
      chk("popErr", popErr, mErr);
`ifdef DRAIN_STATS_EN
      chk("burstCount", burstCount, mBursts);
      chk("flushCount", flushCount, mFlushes);
`else
      chk("burstCount", burstCount, 0);
      chk("flushCount", flushCount, 0);
`endif
    end
    popCnt += fifoPop;
    busyCnt += busy;
    curRun = fifoPop ? curRun + 1 : 0;
    if (curRun > maxRun) maxRun = curRun;
    if (txValid && txReady) begin
      accCnt++; sopCnt += txSop; eopCnt += txEop; bothCnt += (txSop && txEop);
    end
    if (fifoDepth != 0 && firstNz < 0) firstNz = cyc;
    if (fifoPop && firstPop < 0) firstPop = cyc;

    nBurst = mBurst; nRem = mRem; nFirst = mFirst; nTimer = mTimer;
    nValid = mValid; nData = mData; nSop = mSop; nEop = mEop; nErr = mErr;
    nB = mBursts; nF = mFlushes;
    if (mBurst && mRem > 0 && slot && fifoEmpty) nErr = 1;
    if (pop) begin
      nValid = 1; nData = fifoDataOut; nSop = mFirst; nEop = (mRem == 1);
      nRem = mRem - 1; nFirst = 0;
    end else if (slot) begin
      nValid = 0;
    end
    if (mValid && txReady && mEop) begin
      nB = mBursts + 16'd1; nBurst = 0;
    end
    if (!mBurst) begin
      full  = enable && depth >= eff;
      flush = enable && depth != 0 && tmo != 0 && mTimer == tmo - 1;
      if (full) begin
        nBurst = 1; nRem = eff; nFirst = 1; nTimer = 0;
      end else if (flush) begin
        nBurst = 1; nRem = (depth < eff) ? depth : eff; nFirst = 1; nTimer = 0;
        nF = mFlushes + 16'd1;
      end else if (!enable || depth == 0) begin
        nTimer = 0;
      end else if (mTimer < 4095) begin
        nTimer = mTimer + 1;
      end
    end
    rstNow = resetCore;
    if (rstNow) begin
      nBurst = 0; nRem = 0; nFirst = 0; nTimer = 0; nValid = 0; nData = '0;
      nSop = 0; nEop = 0; nErr = 0; nB = '0; nF = '0;
    end
    doPop = fifoPop;
    @(posedge clk);
    #1;
    mBurst = nBurst; mRem = nRem; mFirst = nFirst; mTimer = nTimer;
    mValid = nValid; mData = nData; mSop = nSop; mEop = nEop; mErr = nErr;
    mBursts = nB; mFlushes = nF;
    if (rstNow) mKnown = 1;
    if (doPop && q.size() > 0) void'(q.pop_front());
    if (pushN > 0) begin
      q.push_back(nextWord); nextWord++; pushN--;
    end
    driveFifo();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic doReset();
    resetCore = 1'b1;
    run(2);
    resetCore = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    driveFifo();
    clearStats();
    doReset();
    chk("rst_txValid", txValid, 0);
    chk("rst_fifoPop", fifoPop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_popErr", popErr, 0);
    chk("rst_sopeop", {txSop, txEop}, 0);
    chk("rst_txData", txData, 0);

    // Full bursts: 20 words, length 8 -> two bursts, 4 words left
    preload(20);
    cfgBurstLen = 5'd8; enable = 1'b1; clearStats();
    run(30);
    chk("full_pops", popCnt, 16);
    chk("full_left", q.size(), 4);
    chk("full_run", maxRun, 8);
    chk("full_sop", sopCnt, 2);
    chk("full_eop", eopCnt, 2);

    // Backpressure
    enable = 1'b0; doReset(); q.delete(); preload(4);
    cfgBurstLen = 5'd4; enable = 1'b1; clearStats();
    for (int k = 0; k < 30; k++) begin
      txReady = (k % 3 == 0);
      cycle();
    end
    txReady = 1'b1;
    chk("bp_pops", popCnt, 4);
    chk("bp_eop", eopCnt, 1);
    chk("bp_left", q.size(), 0);

    // Timeout flush of a 3-word partial burst
    enable = 1'b0; doReset(); q.delete(); driveFifo();
    cfgBurstLen = 5'd16; cfgTimeout = 12'd100; enable = 1'b1; clearStats();
    pushN = 3;
    for (int k = 0; k < 200 && firstPop < 0; k++) cycle();
    run(10);
    chk("tmo_delay", firstPop - firstNz, 100);
    chk("tmo_pops", popCnt, 3);
    chk("tmo_sop", sopCnt, 1);
    chk("tmo_eop", eopCnt, 1);
`ifdef DRAIN_STATS_EN
    chk("tmo_flushCount", flushCount, 1);
`endif
    cfgTimeout = 12'd0;

    // Length 0 -> single-word bursts
    enable = 1'b0; doReset(); q.delete(); preload(3);
    cfgBurstLen = 5'd0; enable = 1'b1; clearStats();
    run(20);
    chk("len0_pops", popCnt, 3);
    chk("len0_both", bothCnt, 3);

    // Length 31 -> clamped to 16
    enable = 1'b0; doReset(); q.delete(); preload(20);
    cfgBurstLen = 5'd31; enable = 1'b1; clearStats();
    run(30);
    chk("len31_pops", popCnt, 16);
    chk("len31_run", maxRun, 16);
    chk("len31_left", q.size(), 4);

    // Timeout disabled, partial fill never drains
    enable = 1'b0; doReset(); q.delete(); preload(5);
    cfgBurstLen = 5'd8; enable = 1'b1; clearStats();
    run(300);
    chk("notmo_pops", popCnt, 0);
    chk("notmo_busy", busyCnt, 0);

    // Reset mid-burst
    enable = 1'b0; doReset(); q.delete(); preload(20);
    cfgBurstLen = 5'd8; enable = 1'b1; clearStats();
    for (int k = 0; k < 40 && accCnt < 2; k++) cycle();
    chk("rstmid_reached", accCnt, 2);
    resetCore = 1'b1;
    cycle();
    resetCore = 1'b0;
    chk("rstmid_txValid", txValid, 0);
    chk("rstmid_fifoPop", fifoPop, 0);
    chk("rstmid_busy", busy, 0);
    clearStats();
    run(11);
    chk("rstmid_sop", sopCnt, 1);
    chk("rstmid_eop", eopCnt, 1);

    // Starved FIFO mid-burst
    enable = 1'b0; doReset(); q.delete(); preload(20);
    cfgBurstLen = 5'd8; enable = 1'b1; clearStats();
    run(4);
    chk("err_prepops", popCnt, 3);
    forceEmpty = 1'b1; driveFifo(); clearStats();
    run(5);
    chk("err_nopop", popCnt, 0);
    chk("err_flag", popErr, 1);
    forceEmpty = 1'b0; driveFifo(); clearStats();
    run(30);
    chk("err_resume_pops", popCnt, 13);
    chk("err_left", q.size(), 4);
    chk("err_sticky", popErr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
